// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-clock enable, 640x480@60 sync timing and pixel coords.
// Ports: clk, rst (async, active-high); pix_ce; h_cnt/v_cnt raw counters;
// de, pix_x, pix_y undelayed; line_start, frame_start; hsync, vsync, de_d
// delayed PIPE_DLY pixel ticks. Define VGA_TESTPAT_EN to add testpat_en
// input and tp_rgb colour-bar output (aligned with de_d).
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACT    = 640,
  parameter int H_FP     = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACT    = 480,
  parameter int V_FP     = 10,
  parameter int PIPE_DLY = 2
) (
  input  logic        clk,
  input  logic        rst,
`ifdef VGA_TESTPAT_EN
  input  logic        testpat_en,
  output logic [11:0] tp_rgb,
`endif
  output logic        pix_ce,
  output logic [9:0]  h_cnt,
  output logic [9:0]  v_cnt,
  output logic        de,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        line_start,
  output logic        frame_start,
  output logic        hsync,
  output logic        vsync,
  output logic        de_d
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;

  localparam logic [3:0] DIV_MAX = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_MAX = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_AS  = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_AE  = 10'(H_SYNC + H_BP + H_ACT);
  localparam logic [9:0] V_AS  = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_AE  = 10'(V_SYNC + V_BP + V_ACT);
  localparam logic [9:0] HS_W  = 10'(H_SYNC);
  localparam logic [9:0] VS_W  = 10'(V_SYNC);

`ifdef VGA_TESTPAT_EN
  localparam int DW = 15;
`else
  localparam int DW = 3;
`endif
  // Inactive delay-line word: hsync=1, vsync=1, de=0, colour 0.
  localparam logic [DW-1:0] DLY_RST = DW'(3'b110);

  logic [3:0] div_cnt;
  logic [3:0] div_nxt;
  logic [9:0] h_nxt;
  logic [9:0] v_nxt;
  logic [9:0] px_nxt;
  logic       act_nxt;
  logic       hs_u;
  logic       vs_u;
  logic [DW-1:0] und;
  logic [DW-1:0] dly_out;

  always_comb begin
    div_nxt = (div_cnt == DIV_MAX) ? 4'd0 : div_cnt + 4'd1;
  end

  // pix_ce is registered from the next divider value so it is high
  // exactly while div_cnt == CLK_DIV-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      pix_ce  <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      pix_ce  <= (div_nxt == DIV_MAX);
    end
  end

  // Decode is done on the next counter values so every registered
  // output describes the counters loaded at the same edge.
  always_comb begin
    h_nxt = (h_cnt == H_MAX) ? 10'd0 : h_cnt + 10'd1;
    v_nxt = v_cnt;
    if (h_cnt == H_MAX) begin
      v_nxt = (v_cnt == V_MAX) ? 10'd0 : v_cnt + 10'd1;
    end
    act_nxt = (h_nxt >= H_AS) && (h_nxt < H_AE) &&
              (v_nxt >= V_AS) && (v_nxt < V_AE);
    px_nxt = h_nxt - H_AS;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      de          <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      hs_u        <= 1'b1;
      vs_u        <= 1'b1;
    end else if (pix_ce) begin
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      de          <= act_nxt;
      pix_x       <= act_nxt ? px_nxt : 10'd0;
      pix_y       <= act_nxt ? v_nxt - V_AS : 10'd0;
      line_start  <= (h_nxt == 10'd0);
      frame_start <= (h_nxt == 10'd0) && (v_nxt == 10'd0);
      hs_u        <= !(h_nxt < HS_W);
      vs_u        <= !(v_nxt < VS_W);
    end
  end

`ifdef VGA_TESTPAT_EN
  logic [11:0] tp_u;
  logic [11:0] bar;

  always_comb begin
    bar = 12'h000;
    unique case (px_nxt[9:7])
      3'd0: bar = 12'hFFF;
      3'd1: bar = 12'hFF0;
      3'd2: bar = 12'h0FF;
      3'd3: bar = 12'h0F0;
      3'd4: bar = 12'hF0F;
      3'd5: bar = 12'hF00;
      3'd6: bar = 12'h00F;
      3'd7: bar = 12'h000;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tp_u <= '0;
    end else if (pix_ce) begin
      tp_u <= (act_nxt && px_nxt < 10'd640) ? bar : 12'h000;
    end
  end

  assign und = {tp_u, hs_u, vs_u, de};
`else
  assign und = {hs_u, vs_u, de};
`endif

  generate
    if (PIPE_DLY == 0) begin : g_nodly
      assign dly_out = und;
    end else begin : g_dly
      logic [DW-1:0] sr [PIPE_DLY];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < PIPE_DLY; i++) begin
            sr[i] <= DLY_RST;
          end
        end else if (pix_ce) begin
          sr[0] <= und;
          for (int i = 1; i < PIPE_DLY; i++) begin
            sr[i] <= sr[i-1];
          end
        end
      end
      assign dly_out = sr[PIPE_DLY-1];
    end
  endgenerate

  assign hsync = dly_out[2];
  assign vsync = dly_out[1];
  assign de_d  = dly_out[0];

`ifdef VGA_TESTPAT_EN
  assign tp_rgb = (testpat_en && de_d) ? dly_out[14:3] : 12'h000;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: bench for vga_timing_gen, full horizontal timing with a
// shortened 10-line frame; per-tick scoreboard plus reset/wrap sequences.
module tb_vga_timing_gen;

  localparam int DIV = 4;
  localparam int HT  = 800;
  localparam int VS  = 2;
  localparam int VB  = 3;
  localparam int VA  = 4;
  localparam int VF  = 1;
  localparam int VT  = VS + VB + VA + VF;
  localparam int D   = 2;

  logic       clk;
  logic       rst;
  logic       pix_ce;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       de;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       line_start;
  logic       frame_start;
  logic       hsync;
  logic       vsync;
  logic       de_d;

  vga_timing_gen #(
    .CLK_DIV (DIV),
    .V_SYNC  (VS),
    .V_BP    (VB),
    .V_ACT   (VA),
    .V_FP    (VF),
    .PIPE_DLY(D)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .pix_ce     (pix_ce),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .de         (de),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .line_start (line_start),
    .frame_start(frame_start),
    .hsync      (hsync),
    .vsync      (vsync),
    .de_d       (de_d)
  );

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic [9:0] px;
    logic [9:0] py;
    logic       de;
    logic       ls;
    logic       fs;
    logic       hs;
    logic       vs;
    logic       ded;
  } obs_t;

  typedef struct packed {
    int   t;
    obs_t o;
  } exp_t;

  typedef struct {
    int         k;
    logic       pce;
    logic [9:0] h;
  } vec_t;

  int n_chk = 0;
  int n_err = 0;

  exp_t       sb_q[$];
  logic [2:0] hist[$];
  int m, mh, mv, mt;

  bit stat_done = 0;
  int ls_cnt = 0, fs_cnt = 0, de_cnt = 0;
  int px_max = 0, py_max = 0;
  int hs_low = 0, vs_low = 0, ded_cnt = 0;
  int run = 0, run_max = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic obs_t dut_obs();
    obs_t o;
    o.h   = h_cnt;
    o.v   = v_cnt;
    o.px  = pix_x;
    o.py  = pix_y;
    o.de  = de;
    o.ls  = line_start;
    o.fs  = frame_start;
    o.hs  = hsync;
    o.vs  = vsync;
    o.ded = de_d;
    return o;
  endfunction

  // Reference model: own divider, counters and a FIFO delay line.
  always @(posedge clk) begin
    exp_t e;
    logic [2:0] d;
    if (rst) begin
      m = 0; mh = 0; mv = 0; mt = 0;
      sb_q.delete();
      hist.delete();
      for (int i = 0; i < D; i++) hist.push_back(3'b110);
    end else if (m == DIV - 1) begin
      m = 0;
      mt++;
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh++;
      end
      e.t    = mt;
      e.o.h  = 10'(mh);
      e.o.v  = 10'(mv);
      e.o.de = (mh >= 144 && mh < 784 &&
                mv >= VS + VB && mv < VS + VB + VA);
      e.o.px = e.o.de ? 10'(mh - 144) : 10'd0;
      e.o.py = e.o.de ? 10'(mv - VS - VB) : 10'd0;
      e.o.ls = (mh == 0);
      e.o.fs = (mh == 0 && mv == 0);
      hist.push_back({mh >= 96, mv >= VS, e.o.de});
      d = hist.pop_front();
      {e.o.hs, e.o.vs, e.o.ded} = d;
      sb_q.push_back(e);
    end else begin
      m++;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    obs_t g;
    chk("pix_ce", 64'(pix_ce), 64'(m == DIV - 1));
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      g = dut_obs();
      chk($sformatf("tick%0d", e.t), 64'(g), 64'(e.o));
      if (!stat_done && e.t >= 1 && e.t <= HT * VT) begin
        ls_cnt += int'(line_start);
        fs_cnt += int'(frame_start);
        de_cnt += int'(de);
        if (de && int'(pix_x) > px_max) px_max = int'(pix_x);
        if (de && int'(pix_y) > py_max) py_max = int'(pix_y);
      end
      if (!stat_done && e.t > D && e.t <= HT * VT + D) begin
        hs_low  += int'(!hsync);
        vs_low  += int'(!vsync);
        ded_cnt += int'(de_d);
        if (!hsync) begin
          run++;
        end else begin
          if (run > run_max) run_max = run;
          run = 0;
        end
      end
    end
  end

  task automatic next_tick();
    int k = 0;
    while (!pix_ce && k < 2 * DIV) begin
      @(negedge clk);
      k++;
    end
    if (!pix_ce) begin
      n_chk++;
      n_err++;
      $display("FAIL tick_timeout got=0 exp=1");
    end
    @(negedge clk);
  endtask

  task automatic wait_hv(input int h, input int v, input int lim);
    int k = 0;
    while (!(int'(h_cnt) == h && int'(v_cnt) == v) && k < lim) begin
      next_tick();
      k++;
    end
    chk("reach_hv", {h_cnt, v_cnt}, {10'(h), 10'(v)});
  endtask

  initial begin
    vec_t tbl[9];
    obs_t rst_obs;
    int   cur;

    tbl[0] = '{1,  1'b0, 10'd0};
    tbl[1] = '{2,  1'b0, 10'd0};
    tbl[2] = '{3,  1'b1, 10'd0};
    tbl[3] = '{4,  1'b0, 10'd1};
    tbl[4] = '{5,  1'b0, 10'd1};
    tbl[5] = '{7,  1'b1, 10'd1};
    tbl[6] = '{8,  1'b0, 10'd2};
    tbl[7] = '{11, 1'b1, 10'd2};
    tbl[8] = '{12, 1'b0, 10'd3};

    rst_obs    = '0;
    rst_obs.hs = 1'b1;
    rst_obs.vs = 1'b1;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_state", 64'(dut_obs()), 64'(rst_obs));
    chk("reset_pix_ce", 64'(pix_ce), 64'd0);

    rst = 1'b0;
    cur = 0;
    for (int i = 0; i < 9; i++) begin
      while (cur < tbl[i].k) begin
        @(negedge clk);
        cur++;
      end
      chk($sformatf("div_ce_clk%0d", tbl[i].k), 64'(pix_ce),
          64'(tbl[i].pce));
      chk($sformatf("div_h_clk%0d", tbl[i].k), 64'(h_cnt),
          64'(tbl[i].h));
    end

    wait_hv(HT - 1, VT - 1, HT * VT + 10);
    next_tick();
    chk("wrap_h", 64'(h_cnt), 64'd0);
    chk("wrap_v", 64'(v_cnt), 64'd0);
    chk("wrap_fs", 64'(frame_start), 64'd1);
    chk("wrap_ls", 64'(line_start), 64'd1);
    chk("wrap_vs_t0", 64'(vsync), 64'd1);
    next_tick();
    chk("wrap_vs_t1", 64'(vsync), 64'd1);
    next_tick();
    chk("wrap_vs_t2", 64'(vsync), 64'd0);
    next_tick();

    chk("frame_ls", 64'(ls_cnt), 64'(VT));
    chk("frame_fs", 64'(fs_cnt), 64'd1);
    chk("frame_de", 64'(de_cnt), 64'(640 * VA));
    chk("frame_px_max", 64'(px_max), 64'd639);
    chk("frame_py_max", 64'(py_max), 64'(VA - 1));
    chk("frame_hs_low", 64'(hs_low), 64'(96 * VT));
    chk("frame_hs_run", 64'(run_max), 64'd96);
    chk("frame_vs_low", 64'(vs_low), 64'(HT * VS));
    chk("frame_de_d", 64'(ded_cnt), 64'(640 * VA));
    stat_done = 1;

    wait_hv(100, 5, HT * VT + 10);
    #2 rst = 1'b1;
    #1;
    chk("midrst_now", 64'(dut_obs()), 64'(rst_obs));
    chk("midrst_ce", 64'(pix_ce), 64'd0);
    repeat (3) @(negedge clk);
    chk("midrst_hold", 64'(dut_obs()), 64'(rst_obs));
    rst = 1'b0;

    next_tick();
    chk("restart_h1", 64'(h_cnt), 64'd1);
    chk("restart_hs_t1", 64'(hsync), 64'd1);
    next_tick();
    chk("restart_hs_t2", 64'(hsync), 64'd1);
    chk("restart_ded_t2", 64'(de_d), 64'd0);
    next_tick();
    chk("restart_hs_t3", 64'(hsync), 64'd0);

    wait_hv(0, 1, HT + 10);
    next_tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
